// File: rtl/score_display.sv
// score_display: converts a 16-bit binary score to five BCD digits with a
// one-bit-per-clock double-dabble and scans them onto the Nexys-4 8-digit
// multiplexed seven-segment display. Scanning runs independently of conversion.
module score_display #(
    parameter int unsigned SCAN_BITS = 18,
    parameter bit          BLANK_LZ  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,      // asynchronous, active-low
    input  logic [15:0] score,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned DIGITS  = 5;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned AN_W    = 8;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned IDX_W   = 3;

    localparam logic [CNT_W-1:0] ITERATIONS = CNT_W'(SCORE_W);
    localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;
    localparam logic [AN_W-1:0]  AN_OFF     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   shift_q, shift_d;
    logic [SCORE_W-1:0]   last_q, last_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     disp_q, disp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [AN_W-1:0]      an_q, an_d;
    logic [SEG_W-1:0]     seg_q, seg_d;

    logic [BCD_W-1:0]     adj;
    logic [IDX_W-1:0]     idx;
    logic [DIGITS-1:0]    blank;
    logic [3:0]           cur;
    logic                 cur_blank;

    // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (score != last_q) begin
                    shift_d = score;
                    last_d  = score;
                    bcd_d   = '0;
                    cnt_d   = ITERATIONS;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                disp_d  = bcd_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Conversion state, shift/BCD registers and the display register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            last_q  <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign idx    = scan_q[SCAN_BITS-1 -: IDX_W];
    assign scan_d = scan_q + SCAN_BITS'(1);

    // Leading-zero blanking, current digit select and anode/segment decode.
    always_comb begin
        blank     = '0;
        an_d      = AN_OFF;
        seg_d     = SEG_BLANK;
        cur       = disp_q[3:0];
        cur_blank = 1'b0;

        if (BLANK_LZ) begin
            blank[4] = (disp_q[19:16] == 4'd0);
            for (int k = 3; k >= 1; k--) begin
                blank[k] = blank[k+1] && (disp_q[4*k +: 4] == 4'd0);
            end
        end

        case (idx)
            3'd0: begin cur = disp_q[3:0];   cur_blank = blank[0]; an_d = 8'hFE; end
            3'd1: begin cur = disp_q[7:4];   cur_blank = blank[1]; an_d = 8'hFD; end
            3'd2: begin cur = disp_q[11:8];  cur_blank = blank[2]; an_d = 8'hFB; end
            3'd3: begin cur = disp_q[15:12]; cur_blank = blank[3]; an_d = 8'hF7; end
            3'd4: begin cur = disp_q[19:16]; cur_blank = blank[4]; an_d = 8'hEF; end
            default: begin
                an_d = AN_OFF;
            end
        endcase

        if (an_d != AN_OFF) begin
            seg_d = cur_blank ? SEG_BLANK : seg_encode(cur);
        end
    end

    // Free-running scan counter and registered display drive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_q <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
        end else begin
            scan_q <= scan_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = busy_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: scoreboard of expected digit patterns,
// one instance with leading-zero blanking and one without, SCAN_BITS = 6.
module tb_score_display;

    localparam int unsigned SB = 6;

    logic        clk;
    logic        rst;
    logic [15:0] score;
    logic [7:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb, busy, busy_nb;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [15:0] val;
        logic [34:0] s_bl;
        logic [34:0] s_nb;
    } exp_t;

    exp_t sb_q[$];

    logic [6:0] cap_s [5];
    logic [6:0] cap_n [5];
    int         cap_cnt [5];
    int         ff_cnt, order_err, mix_err, an_err;
    logic       busy_seen, dp_bad;

    score_display #(.SCAN_BITS(SB), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .score(score),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    score_display #(.SCAN_BITS(SB), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .score(score),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb), .busy(busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected segment codes for digits 4..0 packed as 5 x 7 bits.
    function automatic logic [34:0] model_segs(input int val, input bit blank);
        logic [34:0] r;
        int d, p;
        bit lead;
        r = '0;
        lead = blank;
        p = 10000;
        for (int k = 4; k >= 0; k--) begin
            d = (val / p) % 10;
            p = p / 10;
            if (d != 0) lead = 1'b0;
            r[k*7 +: 7] = (lead && k > 0) ? 7'h7F : seg_code(d);
        end
        return r;
    endfunction

    function automatic logic [7:0] next_an(input logic [7:0] a);
        case (a)
            8'hFE:   return 8'hFD;
            8'hFD:   return 8'hFB;
            8'hFB:   return 8'hF7;
            8'hF7:   return 8'hEF;
            8'hEF:   return 8'hFF;
            8'hFF:   return 8'hFE;
            default: return 8'h00;
        endcase
    endfunction

    task automatic drive_score(input logic [15:0] v);
        exp_t e;
        score = v;
        e.val  = v;
        e.s_bl = model_segs(int'(v), 1'b1);
        e.s_nb = model_segs(int'(v), 1'b0);
        sb_q.push_back(e);
    endtask

    task automatic wait_busy_rise(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (busy !== 1'b1 && i < 8) begin
            i++;
            @(negedge clk);
        end
        check_eq(tag, 32'(busy), 32'd1);
    endtask

    task automatic count_busy(output int len);
        len = 0;
        while (busy === 1'b1 && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Observe one full 64-cycle scan of both instances.
    task automatic capture();
        logic [7:0] prev;
        logic [7:0] sel;
        bit hit;
        for (int k = 0; k < 5; k++) begin
            cap_cnt[k] = 0;
            cap_s[k] = '0;
            cap_n[k] = '0;
        end
        ff_cnt = 0; order_err = 0; mix_err = 0; an_err = 0;
        busy_seen = 1'b0; dp_bad = 1'b0;
        prev = an;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || busy_nb !== 1'b0) busy_seen = 1'b1;
            if (dp !== 1'b1 || dp_nb !== 1'b1) dp_bad = 1'b1;
            if (an !== an_nb) an_err++;
            if (an !== prev && an !== next_an(prev)) order_err++;
            prev = an;
            if (an === 8'hFF) begin
                ff_cnt++;
            end else begin
                hit = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    sel = ~(8'd1 << k);
                    if (an === sel) begin
                        hit = 1'b1;
                        if (cap_cnt[k] == 0) begin
                            cap_s[k] = seg;
                            cap_n[k] = seg_nb;
                        end else if (seg !== cap_s[k] || seg_nb !== cap_n[k]) begin
                            mix_err++;
                        end
                        cap_cnt[k]++;
                    end
                end
                if (!hit) an_err++;
            end
        end
    endtask

    task automatic verify(input string tag, input exp_t e);
        capture();
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("%s seg d%0d", tag, k), 32'(cap_s[k]), 32'(e.s_bl[k*7 +: 7]));
            check_eq($sformatf("%s seg_nb d%0d", tag, k), 32'(cap_n[k]), 32'(e.s_nb[k*7 +: 7]));
            check_eq($sformatf("%s dwell d%0d", tag, k), 32'(cap_cnt[k]), 32'd8);
        end
        check_eq({tag, " an_off_cycles"}, 32'(ff_cnt), 32'd24);
        check_eq({tag, " an_order"}, 32'(order_err), 32'd0);
        check_eq({tag, " seg_stable"}, 32'(mix_err), 32'd0);
        check_eq({tag, " an_bad"}, 32'(an_err), 32'd0);
        check_eq({tag, " busy_idle"}, 32'(busy_seen), 32'd0);
        check_eq({tag, " dp_off"}, 32'(dp_bad), 32'd0);
    endtask

    task automatic run_conv(input string tag, input logic [15:0] v);
        int len;
        drive_score(v);
        wait_busy_rise({tag, " busy_rise"});
        count_busy(len);
        check_eq({tag, " busy_len"}, 32'(len), 32'd17);
        verify(tag, sb_q.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " an"}, 32'(an), 32'hFF);
        check_eq({tag, " seg"}, 32'(seg), 32'h7F);
        check_eq({tag, " busy"}, 32'(busy), 32'd0);
        check_eq({tag, " dp"}, 32'(dp), 32'd1);
        check_eq({tag, " an_nb"}, 32'(an_nb), 32'hFF);
        check_eq({tag, " seg_nb"}, 32'(seg_nb), 32'h7F);
    endtask

    initial begin
        int   len, low, saw, i;
        logic [7:0] prev;
        bit   found;
        exp_t e5;

        n_checks = 0;
        n_errors = 0;
        rst   = 1'b0;
        score = 16'd0;

        // Reset with zero score, then one scan of the zero display.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_reset_outputs($sformatf("reset%0d", c));
        end
        rst = 1'b1;
        drive_score(16'd0);
        verify("zero", sb_q.pop_front());

        run_conv("s1234", 16'd1234);
        run_conv("s65535", 16'd65535);
        run_conv("s100", 16'd100);

        // Change mid-conversion, phased so digit 0 is scanned between conversions.
        prev = an; i = 0; found = 1'b0;
        while (!found && i < 80) begin
            @(negedge clk);
            i++;
            if (an === 8'hFE && prev !== 8'hFE) found = 1'b1;
            prev = an;
        end
        check_eq("align an_fe", 32'(found), 32'd1);
        repeat (40) @(negedge clk);
        drive_score(16'd5);
        wait_busy_rise("mid busy_rise");
        len = 0;
        while (busy === 1'b1 && len < 40) begin
            len++;
            if (len == 5) drive_score(16'd9);
            @(negedge clk);
        end
        check_eq("mid busy_len1", 32'(len), 32'd17);
        low = 0;
        while (busy !== 1'b1 && low < 10) begin
            low++;
            @(negedge clk);
        end
        check_eq("mid idle_gap", 32'(low), 32'd1);
        e5 = sb_q.pop_front();
        saw = 0; len = 0;
        while (busy === 1'b1 && len < 40) begin
            len++;
            if (an === 8'hFE) begin
                saw++;
                check_eq("mid d0_first", 32'(seg), 32'(e5.s_bl[6:0]));
            end
            @(negedge clk);
        end
        check_eq("mid busy_len2", 32'(len), 32'd17);
        check_eq("mid d0_samples", 32'(saw), 32'd8);
        verify("s9", sb_q.pop_front());

        // Reset during conversion of 4321 with 7 on display.
        run_conv("s7", 16'd7);
        drive_score(16'd4321);
        wait_busy_rise("rstmid busy_rise");
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstmid held");
        rst = 1'b1;
        wait_busy_rise("rstmid restart");
        len = 0;
        while (busy === 1'b1 && len < 40) begin
            len++;
            if (len == 2) begin
                check_eq("rstmid an", 32'(an), 32'hFE);
                check_eq("rstmid d0_zero", 32'(seg), 32'h40);
                check_eq("rstmid d0_zero_nb", 32'(seg_nb), 32'h40);
            end
            @(negedge clk);
        end
        check_eq("rstmid busy_len", 32'(len), 32'd17);
        verify("s4321", sb_q.pop_front());

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
